det_seq: RTL

- Sequential, parametrised NxN determinant engine for the matrix coprocessor. It replaces the fixed combinational cofactor trees with a single multiply-subtract datapath.
- Uses fraction-free Gaussian elimination (Bareiss) with row-swap pivoting.
- Start/busy/done handshake, W-bit signed result and overflow flag, consistent with the existing det/multiplier outputs.

---
 rtl/det_seq_if.sv | 15 +
 rtl/det_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/det_seq_if.sv
// Start/busy/done handshake and matrix/result bus for the determinant engine.
interface det_seq_if #(
  parameter int N = 5,
  parameter int W = 8
);
  logic                    start;
  logic [N*N*W-1:0]        matrix;
  logic                    busy;
  logic                    done;
  logic signed [W-1:0]     det;
  logic                    ovf;

  modport master (output start, output matrix, input busy, input done, input det, input ovf);
  modport slave  (input start, input matrix, output busy, output done, output det, output ovf);
endinterface

// File: rtl/det_seq.sv
// Sequential NxN determinant via fraction-free (Bareiss) elimination with row-swap pivoting.
// Optional DET_SAT_EN: saturate det when the final result does not fit W bits.
//
// state  | meaning
// IDLE   | waiting for start; det/ovf hold last result
// PIVOT  | probe row r for a non-zero a[r][k]; swap into row k
// ELIM   | one Bareiss update of a[i][j] per cycle
// FINISH | apply sign, range-check, publish det/ovf
module det_seq #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int ACC_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  det_seq_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int PW = 2 * ACC_W;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, PIVOT, ELIM, FINISH} state_t;

  state_t                   state, state_nx;
  logic signed [ACC_W-1:0]  a [N][N];
  logic signed [ACC_W-1:0]  prev;
  logic [IW-1:0]            k, r, i, j;
  logic                     neg, sing, iovf;

  logic signed [PW-1:0]     p1, p2;
  logic signed [PW:0]       diff, quo;
  logic                     step_ovf;
  logic                     pivot_hit, last_elem;
  logic signed [ACC_W:0]    last_v, res;
  logic                     res_oor;
  logic [W-1:0]             det_fin;

  function automatic logic fits_acc(input logic signed [PW:0] v);
    return (&v[PW:ACC_W-1]) | ~(|v[PW:ACC_W-1]);
  endfunction

  always_comb begin
    p1        = PW'(a[k][k]) * PW'(a[i][j]);
    p2        = PW'(a[i][k]) * PW'(a[k][j]);
    diff      = (PW+1)'(p1) - (PW+1)'(p2);
    // Bareiss guarantees exact division; prev is never zero once loaded
    quo       = diff / (PW+1)'(prev);
    step_ovf  = ~fits_acc((PW+1)'(p1)) | ~fits_acc((PW+1)'(p2)) |
                ~fits_acc(diff) | ~fits_acc(quo);
    pivot_hit = (a[r][k] != '0);
    last_elem = (i == LAST) && (j == LAST);

    last_v  = (ACC_W+1)'(a[N-1][N-1]);
    res     = sing ? '0 : (neg ? -last_v : last_v);
    res_oor = ~((&res[ACC_W:W-1]) | ~(|res[ACC_W:W-1]));
`ifdef DET_SAT_EN
    if (res_oor)
      det_fin = res[ACC_W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      det_fin = res[W-1:0];
`else
    det_fin = res[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (bus.start) state_nx = PIVOT;
      PIVOT: begin
        if (pivot_hit)        state_nx = ELIM;
        else if (r == LAST)   state_nx = FINISH;
      end
      ELIM: begin
        if (last_elem) state_nx = ((k + 1'b1) == LAST) ? FINISH : PIVOT;
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < N; x++)
        for (int y = 0; y < N; y++)
          a[x][y] <= '0;
      prev     <= ACC_W'(1);
      k        <= '0;
      r        <= '0;
      i        <= '0;
      j        <= '0;
      neg      <= 1'b0;
      sing     <= 1'b0;
      iovf     <= 1'b0;
      bus.det  <= '0;
      bus.ovf  <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int x = 0; x < N; x++)
              for (int y = 0; y < N; y++)
                a[x][y] <= ACC_W'($signed(bus.matrix[(N*N-1-(x*N+y))*W +: W]));
            prev <= ACC_W'(1);
            neg  <= 1'b0;
            sing <= 1'b0;
            iovf <= 1'b0;
            k    <= '0;
            r    <= '0;
          end
        end
        PIVOT: begin
          if (pivot_hit) begin
            for (int c = 0; c < N; c++) begin
              a[k][c] <= a[r][c];
              a[r][c] <= a[k][c];
            end
            if (r != k) neg <= ~neg;
            i <= k + 1'b1;
            j <= k + 1'b1;
          end else begin
            if (r == LAST) sing <= 1'b1;
            r <= r + 1'b1;
          end
        end
        ELIM: begin
          a[i][j] <= quo[ACC_W-1:0];
          iovf    <= iovf | step_ovf;
          if (j == LAST) begin
            j <= k + 1'b1;
            i <= i + 1'b1;
            if (i == LAST) begin
              prev <= a[k][k];
              k    <= k + 1'b1;
              r    <= k + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        FINISH: begin
          bus.det  <= det_fin;
          bus.ovf  <= iovf | res_oor;
          bus.done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
